// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the three channels around the load/store sequencer:
//   request  : req_valid/req_ready handshake plus we, size, signed, addr, wdata
//   response : rsp_valid/rsp_ready handshake plus rdata, err
//   memory   : byte-wide port (addr, wdata, write_en, read_en, read_data)
//   slave  modport : the sequencer (consumes requests, drives memory port)
//   master modport : execute stage / memory side seen from the outside
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [7:0]        mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_wdata, mem_write_en, mem_read_en,
    input  mem_read_data
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_wdata, mem_write_en, mem_read_en,
    output mem_read_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Byte-sequencing load/store unit. One byte/halfword/word request is
//   accepted in IDLE, split into N single-byte memory accesses (ACCESS,
//   N cycles, lowest address first) and answered once in RESP.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : mem_access_unit_if.slave (request, response, memory port)
//   ADDR_W must match the ADDR_W of the connected interface instance.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                       we;
    logic [1:0]                 size;
    logic                       sgn;
    logic [ADDR_W-1:0]          addr;
    logic [NUM_LANES-1:0][7:0]  wdata;
  } req_t;

  state_t                    state, state_n;
  req_t                      rq;
  logic [1:0]                cnt;
  logic [1:0]                last_idx;
  logic                      last;
  logic                      accept;
  logic                      req_bad;
  logic [NUM_LANES-1:0][7:0] asm_q, asm_nxt;
  logic [31:0]               rsp_rdata_q;
  logic                      rsp_err_q;

  // Misaligned or illegal size: answered with an error, memory untouched.
  assign req_bad = (bus.req_size == 2'd3) ||
                   ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

  assign last_idx = (rq.size == 2'd0) ? 2'd0 :
                    (rq.size == 2'd1) ? 2'd1 : 2'd3;
  assign last     = (cnt == last_idx);

  // Assembly lanes: lane l captures the memory byte in the cycle cnt == l
  // of a load. The read is combinational, so the byte is sampled at the
  // same edge its address is presented. All lanes clear on accept so the
  // unused upper lanes read as zero before extension.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign asm_nxt[l] = accept ? 8'h00 :
                        ((state == ACCESS) && !rq.we && (cnt == 2'(l))) ?
                        bus.mem_read_data : asm_q[l];
  end

  function automatic logic [31:0] extend(input logic [31:0] v,
                                         input logic [1:0]  sz,
                                         input logic        sgn);
    case (sz)
      2'd0:    return {{24{sgn & v[7]}},  v[7:0]};
      2'd1:    return {{16{sgn & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n          = state;
    accept           = 1'b0;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = 8'h00;
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_addr = rq.addr + ADDR_W'(cnt);
        if (rq.we) begin
          bus.mem_write_en = 1'b1;
          bus.mem_wdata    = rq.wdata[cnt];
        end else begin
          bus.mem_read_en  = 1'b1;
        end
        if (last) state_n = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq          <= '0;
      cnt         <= 2'd0;
      asm_q       <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      asm_q <= asm_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            rq.we    <= bus.req_we;
            rq.size  <= bus.req_size;
            rq.sgn   <= bus.req_signed;
            rq.addr  <= bus.req_addr;
            rq.wdata <= bus.req_wdata;
            cnt      <= 2'd0;
            if (req_bad) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (last) begin
            // asm_nxt already holds the byte captured at this edge.
            rsp_rdata_q <= rq.we ? 32'h0 : extend(asm_nxt, rq.size, rq.sgn);
            rsp_err_q   <= 1'b0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
  mem_access_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Byte memory: synchronous write, combinational read; pl_* is a bench
  // side preload path.
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;
  always @(posedge clk) begin
    if (pl_en)                 mem[pl_addr] <= pl_data;
    else if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_read_data = mem[bus.mem_addr];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nen;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, walk it through ACCESS and compare the response
  // against the scoreboard entry once rsp_valid rises. Leaves the unit in
  // RESP; finish_rsp performs the handshake.
  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int lat, nen, bad, k;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.nen   = exp_err ? 0 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.lat   = e.nen + 1;
    sb.push_back(e);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble request inputs: the unit must use its latched copy.
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'h5A;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_we    = ~we;
    lat = 1; nen = 0; bad = 0; k = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.mem_write_en || bus.mem_read_en) begin
        nen++;
        if (bus.mem_write_en !== we || bus.mem_read_en !== !we ||
            bus.mem_addr !== 8'(addr + k)) bad++;
      end
      k++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    e = sb.pop_front();
    chk({tag, ".rdata"},   bus.rsp_rdata,   e.rdata);
    chk({tag, ".err"},     32'(bus.rsp_err), 32'(e.err));
    chk({tag, ".latency"}, 32'(lat),         32'(e.lat));
    chk({tag, ".en_cyc"},  32'(nen),         32'(e.nen));
    chk({tag, ".port_seq"}, 32'(bad),        32'd0);
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // Preload under reset, then check reset outputs.
    preload(8'h40, 8'hA5); preload(8'h41, 8'hA5);
    preload(8'h42, 8'hA5); preload(8'h43, 8'hA5);
    preload(8'h22, 8'h00); preload(8'h00, 8'h77);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("rst.mem_port",  {bus.mem_addr, bus.mem_wdata, 14'(0), bus.mem_write_en, bus.mem_read_en}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load.
    run_req("st_w10", 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    finish_rsp("st_w10");
    chk("mem10", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
    run_req("ld_w10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    finish_rsp("ld_w10");

    // Sign/zero extension.
    run_req("st_b20", 1'b1, 2'd0, 1'b0, 8'h20, 32'h1234_5680, 32'h0, 1'b0);
    finish_rsp("st_b20");
    run_req("ld_bs20", 1'b0, 2'd0, 1'b1, 8'h20, 32'h0, 32'hFFFFFF80, 1'b0);
    finish_rsp("ld_bs20");
    run_req("ld_bu20", 1'b0, 2'd0, 1'b0, 8'h20, 32'h0, 32'h00000080, 1'b0);
    finish_rsp("ld_bu20");
    run_req("st_h20", 1'b1, 2'd1, 1'b0, 8'h20, 32'hABCD_9234, 32'h0, 1'b0);
    finish_rsp("st_h20");
    chk("mem20_22", {8'h00, mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h00009234);
    run_req("ld_hs20", 1'b0, 2'd1, 1'b1, 8'h20, 32'h0, 32'hFFFF9234, 1'b0);
    finish_rsp("ld_hs20");
    run_req("ld_hu20", 1'b0, 2'd1, 1'b0, 8'h20, 32'h0, 32'h00009234, 1'b0);
    finish_rsp("ld_hu20");

    // Error cases: no memory enables, 1-edge latency.
    run_req("err_h21", 1'b0, 2'd1, 1'b1, 8'h21, 32'h0, 32'h0, 1'b1);
    finish_rsp("err_h21");
    run_req("err_w22", 1'b1, 2'd2, 1'b0, 8'h22, 32'h1111_1111, 32'h0, 1'b1);
    finish_rsp("err_w22");
    chk("mem22_keep", 32'(mem[8'h22]), 32'h0);
    run_req("err_sz3", 1'b0, 2'd3, 1'b0, 8'h30, 32'h0, 32'h0, 1'b1);
    finish_rsp("err_sz3");

    // Top of memory: no wrap into 0x00.
    run_req("st_wFC", 1'b1, 2'd2, 1'b0, 8'hFC, 32'h0BADF00D, 32'h0, 1'b0);
    finish_rsp("st_wFC");
    chk("memFC", {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]}, 32'h0BADF00D);
    chk("mem00_keep", 32'(mem[8'h00]), 32'h77);
    run_req("ld_wFC", 1'b0, 2'd2, 1'b0, 8'hFC, 32'h0, 32'h0BADF00D, 1'b0);
    finish_rsp("ld_wFC");

    // Backpressure: hold response 5 cycles with a second request pending.
    run_req("bp_ld", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 8'h13;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp.rdata",     bus.rsp_rdata, 32'hDEADBEEF);
      chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp.mem_idle",  32'({bus.mem_write_en, bus.mem_read_en}), 32'd0);
    end
    finish_rsp("bp_ld");
    run_req("bp_2nd", 1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 32'h000000DE, 1'b0);
    finish_rsp("bp_2nd");

    // Reset after two bytes of a word store at 0x40.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 8'h40; bus.req_wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.mem_port", {bus.mem_addr, bus.mem_wdata, 14'(0), bus.mem_write_en, bus.mem_read_en}, 32'h0);
    chk("mrst.rsp", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'h0);
    chk("mrst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("mrst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst.mem40", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hA5A53344);
    #2 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid || bus.mem_write_en) seen++;
      end
      chk("mrst.no_rsp", 32'(seen), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
